// File: rtl/mem_bus_responder_pkg.sv
// mcDefs: shared constants and state encoding for the main-bus memory responder.
package mcDefs;

   localparam int BUSWIDTH = 16;
   localparam int MEMSIZE  = 256;
   localparam int PAGEBITS = 4;
   localparam int BURSTLEN = 4;
   localparam int BEATW    = $clog2(BURSTLEN);

   typedef enum logic [1:0] {IDLE, RD, WR} respState_t;

endpackage

// File: rtl/mem_bus_responder_if.sv
// Processor-side multiplexed main bus: address phase strobe, direction,
// shared address/write-data input and the responder's read-data return path.
interface mem_bus_responder_if #(
   parameter int BUSWIDTH = mcDefs::BUSWIDTH
);

   logic                AddrValid;
   logic                rw;
   logic [BUSWIDTH-1:0] AddrDataIn;
   logic [BUSWIDTH-1:0] AddrDataOut;
   logic                AddrDataOE;

   modport master (
      output AddrValid,
      output rw,
      output AddrDataIn,
      input  AddrDataOut,
      input  AddrDataOE
   );

   modport slave (
      input  AddrValid,
      input  rw,
      input  AddrDataIn,
      output AddrDataOut,
      output AddrDataOE
   );

endinterface

// File: rtl/mem_bus_responder_burst_ctr.sv
// mem_burst_ctr: burst base address register plus beat counter. The array
// address is base + beat, wrapping modulo the array depth (power of two).
module mem_burst_ctr
   import mcDefs::*;
#(
   parameter int ADDRWIDTH = 8
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic                 load,
   input  logic                 inc,
   input  logic                 clear,
   input  logic [ADDRWIDTH-1:0] loadAddr,
   output logic [ADDRWIDTH-1:0] addr,
   output logic                 lastBeat
);

   logic [ADDRWIDTH-1:0] r_base;
   logic [BEATW-1:0]     r_beat;

   // Base is captured on an accepted address phase; beat walks the burst.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_base <= '0;
         r_beat <= '0;
      end else if (load) begin
         r_base <= loadAddr;
         r_beat <= '0;
      end else if (clear) begin
         r_beat <= '0;
      end else if (inc) begin
         r_beat <= r_beat + BEATW'(1);
      end
   end

   assign addr     = r_base + ADDRWIDTH'(r_beat);
   assign lastBeat = (r_beat == BEATW'(BURSTLEN - 1));

endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: main-bus target for one address page. An accepted
// address phase starts a fixed 4-beat read or write burst to the memory array.
// Optional feature macro: MEM_BUS_RESP_PROTOCHK_EN enables the sticky protErr
// flag for address strobes seen mid-burst; otherwise protErr is tied low.
module mem_bus_responder #(
   parameter int                  BUSWIDTH  = mcDefs::BUSWIDTH,
   parameter int                  MEMSIZE   = mcDefs::MEMSIZE,
   parameter int                  PAGEBITS  = mcDefs::PAGEBITS,
   parameter logic [PAGEBITS-1:0] PAGE      = '0,
   localparam int                 ADDRWIDTH = $clog2(MEMSIZE)
) (
   input  logic                 clk,
   input  logic                 resetN,
   mem_bus_responder_if.slave   bus,
   output logic [ADDRWIDTH-1:0] Addr,
   output logic [BUSWIDTH-1:0]  DataIn,
   input  logic [BUSWIDTH-1:0]  DataOut,
   output logic                 rdEn,
   output logic                 wrEn,
   output logic                 protErr
);

   mcDefs::respState_t r_state;
   mcDefs::respState_t w_nextState;

   logic w_pageHit;
   logic w_load;
   logic w_inc;
   logic w_clear;
   logic w_lastBeat;

   // Address bits between the page field and the word address select nothing.
   logic w_unused;
   assign w_unused = &{1'b0, bus.AddrDataIn[BUSWIDTH-PAGEBITS-1:ADDRWIDTH]};

   assign w_pageHit = (bus.AddrDataIn[BUSWIDTH-1 -: PAGEBITS] == PAGE);

   mem_burst_ctr #(
      .ADDRWIDTH (ADDRWIDTH)
   ) u_burst_ctr (
      .clk      (clk),
      .resetN   (resetN),
      .load     (w_load),
      .inc      (w_inc),
      .clear    (w_clear),
      .loadAddr (bus.AddrDataIn[ADDRWIDTH-1:0]),
      .addr     (Addr),
      .lastBeat (w_lastBeat)
   );

   // State register; async reset aborts any burst in progress.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) r_state <= mcDefs::IDLE;
      else         r_state <= w_nextState;
   end

   // Next state, counter control and all array/bus outputs decoded from state.
   always_comb begin
      w_nextState     = r_state;
      w_load          = 1'b0;
      w_inc           = 1'b0;
      w_clear         = 1'b0;
      rdEn            = 1'b0;
      wrEn            = 1'b0;
      DataIn          = '0;
      bus.AddrDataOut = '0;
      bus.AddrDataOE  = 1'b0;
      case (r_state)
         mcDefs::IDLE: begin
            if (bus.AddrValid && w_pageHit) begin
               w_load      = 1'b1;
               w_nextState = bus.rw ? mcDefs::RD : mcDefs::WR;
            end
         end
         mcDefs::RD: begin
            rdEn            = 1'b1;
            bus.AddrDataOE  = 1'b1;
            bus.AddrDataOut = DataOut;
            if (w_lastBeat) begin
               w_clear     = 1'b1;
               w_nextState = mcDefs::IDLE;
            end else begin
               w_inc = 1'b1;
            end
         end
         mcDefs::WR: begin
            wrEn   = 1'b1;
            DataIn = bus.AddrDataIn;
            if (w_lastBeat) begin
               w_clear     = 1'b1;
               w_nextState = mcDefs::IDLE;
            end else begin
               w_inc = 1'b1;
            end
         end
         default: begin
            w_nextState = mcDefs::IDLE;
         end
      endcase
   end

`ifdef MEM_BUS_RESP_PROTOCHK_EN
   logic r_protErr;

   // Sticky flag: an address strobe arrived while a burst was running.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)                                        r_protErr <= 1'b0;
      else if (bus.AddrValid && (r_state != mcDefs::IDLE)) r_protErr <= 1'b1;
   end

   assign protErr = r_protErr;
`else
   assign protErr = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder with a behavioural 256x16 array.
module tb_mem_bus_responder;

`ifdef MEM_BUS_RESP_PROTOCHK_EN
   localparam logic PE = 1'b1;
`else
   localparam logic PE = 1'b0;
`endif

   logic        clk;
   logic        resetN;
   logic [7:0]  Addr;
   logic [15:0] DataIn;
   logic [15:0] DataOut;
   logic        rdEn;
   logic        wrEn;
   logic        protErr;

   logic [15:0] mem [0:255];

   int checks = 0;
   int errors = 0;

   mem_bus_responder_if bus ();

   mem_bus_responder dut (
      .clk     (clk),
      .resetN  (resetN),
      .bus     (bus),
      .Addr    (Addr),
      .DataIn  (DataIn),
      .DataOut (DataOut),
      .rdEn    (rdEn),
      .wrEn    (wrEn),
      .protErr (protErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (wrEn) mem[Addr] <= DataIn;
   end

   assign DataOut = rdEn ? mem[Addr] : 16'h0000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic av, input logic rwv, input logic [15:0] d);
      bus.AddrValid  = av;
      bus.rw         = rwv;
      bus.AddrDataIn = d;
   endtask

   task automatic wrBurst(input string tag, input logic [15:0] hdr,
                          input logic [63:0] data, input logic [31:0] addrs);
      step();
      drive(1'b1, 1'b0, hdr);
      #4;
      chk($sformatf("%s_aph_wrEn", tag), {31'd0, wrEn}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         drive(1'b0, 1'b0, data[63-16*i -: 16]);
         #4;
         chk($sformatf("%s_b%0d_wrEn", tag, i), {31'd0, wrEn}, 32'd1);
         chk($sformatf("%s_b%0d_oe", tag, i), {31'd0, bus.AddrDataOE}, 32'd0);
         chk($sformatf("%s_b%0d_addr", tag, i), {24'd0, Addr}, {24'd0, addrs[31-8*i -: 8]});
         chk($sformatf("%s_b%0d_din", tag, i), {16'd0, DataIn}, {16'd0, data[63-16*i -: 16]});
      end
   endtask

   task automatic rdBurst(input string tag, input logic [15:0] hdr,
                          input logic [63:0] data, input logic [31:0] addrs);
      step();
      drive(1'b1, 1'b1, hdr);
      #4;
      chk($sformatf("%s_aph_oe", tag), {31'd0, bus.AddrDataOE}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         drive(1'b0, 1'b0, 16'h0000);
         #4;
         chk($sformatf("%s_b%0d_rdEn", tag, i), {31'd0, rdEn}, 32'd1);
         chk($sformatf("%s_b%0d_oe", tag, i), {31'd0, bus.AddrDataOE}, 32'd1);
         chk($sformatf("%s_b%0d_wrEn", tag, i), {31'd0, wrEn}, 32'd0);
         chk($sformatf("%s_b%0d_addr", tag, i), {24'd0, Addr}, {24'd0, addrs[31-8*i -: 8]});
         chk($sformatf("%s_b%0d_dout", tag, i), {16'd0, bus.AddrDataOut}, {16'd0, data[63-16*i -: 16]});
      end
   endtask

   task automatic idleChk(input string tag);
      step();
      drive(1'b0, 1'b0, 16'h0000);
      #4;
      chk($sformatf("%s_ctl", tag), {29'd0, rdEn, wrEn, bus.AddrDataOE}, 32'd0);
      chk($sformatf("%s_dout", tag), {16'd0, bus.AddrDataOut}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      resetN = 1'b0;
      drive(1'b0, 1'b0, 16'h0000);

      // Reset state
      #3;
      chk("rst_ctl", {29'd0, rdEn, wrEn, bus.AddrDataOE}, 32'd0);
      chk("rst_dout", {16'd0, bus.AddrDataOut}, 32'd0);
      chk("rst_addr", {24'd0, Addr}, 32'd0);
      chk("rst_din", {16'd0, DataIn}, 32'd0);
      chk("rst_perr", {31'd0, protErr}, 32'd0);
      step();
      resetN = 1'b1;

      // Write then read back a burst at 0x10
      wrBurst("wr10", 16'h0010, {16'h1111, 16'h2222, 16'h3333, 16'h4444}, {8'h10, 8'h11, 8'h12, 8'h13});
      idleChk("wr10_end");
      chk("mem10", {16'd0, mem[8'h10]}, 32'h1111);
      chk("mem11", {16'd0, mem[8'h11]}, 32'h2222);
      chk("mem12", {16'd0, mem[8'h12]}, 32'h3333);
      chk("mem13", {16'd0, mem[8'h13]}, 32'h4444);
      rdBurst("rd10", 16'h0010, {16'h1111, 16'h2222, 16'h3333, 16'h4444}, {8'h10, 8'h11, 8'h12, 8'h13});
      idleChk("rd10_end");

      // Wrapping write at 0xFE, read back-to-back on the next cycle
      wrBurst("wrap", 16'h00FE, {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD}, {8'hFE, 8'hFF, 8'h00, 8'h01});
      rdBurst("wraprd", 16'h00FE, {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD}, {8'hFE, 8'hFF, 8'h00, 8'h01});
      idleChk("wrap_end");
      chk("memFE", {16'd0, mem[8'hFE]}, 32'hAAAA);
      chk("mem00", {16'd0, mem[8'h00]}, 32'hCCCC);
      chk("mem01", {16'd0, mem[8'h01]}, 32'hDDDD);

      // Wrong page is ignored
      step();
      drive(1'b1, 1'b0, 16'h1010);
      #4;
      chk("wp_aph_ctl", {29'd0, rdEn, wrEn, bus.AddrDataOE}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         step();
         drive(1'b0, 1'b0, 16'h5555);
         #4;
         chk($sformatf("wp_c%0d_ctl", i), {29'd0, rdEn, wrEn, bus.AddrDataOE}, 32'd0);
      end
      chk("wp_mem10", {16'd0, mem[8'h10]}, 32'h1111);
      chk("wp_mem11", {16'd0, mem[8'h11]}, 32'h2222);

      // Address strobe in beat 1 of a read: not queued, flagged when enabled
      step();
      drive(1'b1, 1'b1, 16'h0010);
      #4;
      step();
      drive(1'b0, 1'b0, 16'h0000);
      #4;
      chk("pc_b0_dout", {16'd0, bus.AddrDataOut}, 32'h1111);
      step();
      drive(1'b1, 1'b0, 16'h0011);
      #4;
      chk("pc_b1_dout", {16'd0, bus.AddrDataOut}, 32'h2222);
      chk("pc_b1_perr", {31'd0, protErr}, 32'd0);
      step();
      drive(1'b0, 1'b0, 16'h0000);
      #4;
      chk("pc_b2_dout", {16'd0, bus.AddrDataOut}, 32'h3333);
      chk("pc_b2_perr", {31'd0, protErr}, {31'd0, PE});
      step();
      #4;
      chk("pc_b3_dout", {16'd0, bus.AddrDataOut}, 32'h4444);
      chk("pc_b3_oe", {31'd0, bus.AddrDataOE}, 32'd1);
      chk("pc_b3_perr", {31'd0, protErr}, {31'd0, PE});
      idleChk("pc_end0");
      chk("pc_end0_perr", {31'd0, protErr}, {31'd0, PE});
      idleChk("pc_end1");
      chk("pc_end1_perr", {31'd0, protErr}, {31'd0, PE});
      chk("pc_mem11", {16'd0, mem[8'h11]}, 32'h2222);

      // Reset during beat 2 of a write at 0x20
      step();
      drive(1'b1, 1'b0, 16'h0020);
      #4;
      step();
      drive(1'b0, 1'b0, 16'h0A01);
      #4;
      chk("rw_b0_addr", {24'd0, Addr}, 32'h20);
      chk("rw_b0_wrEn", {31'd0, wrEn}, 32'd1);
      step();
      drive(1'b0, 1'b0, 16'h0A02);
      #4;
      chk("rw_b1_addr", {24'd0, Addr}, 32'h21);
      step();
      drive(1'b0, 1'b0, 16'h0A03);
      resetN = 1'b0;
      #4;
      chk("rw_b2_wrEn", {31'd0, wrEn}, 32'd0);
      chk("rw_b2_addr", {24'd0, Addr}, 32'd0);
      chk("rw_b2_din", {16'd0, DataIn}, 32'd0);
      chk("rw_b2_perr", {31'd0, protErr}, 32'd0);
      step();
      resetN = 1'b1;
      drive(1'b0, 1'b0, 16'h0A04);
      #4;
      chk("rw_rel_ctl", {29'd0, rdEn, wrEn, bus.AddrDataOE}, 32'd0);
      chk("rw_mem20", {16'd0, mem[8'h20]}, 32'h0A01);
      chk("rw_mem21", {16'd0, mem[8'h21]}, 32'h0A02);
      chk("rw_mem22", {16'd0, mem[8'h22]}, 32'h0000);
      chk("rw_mem23", {16'd0, mem[8'h23]}, 32'h0000);
      rdBurst("rwrd", 16'h0020, {16'h0A01, 16'h0A02, 16'h0000, 16'h0000}, {8'h20, 8'h21, 8'h22, 8'h23});
      idleChk("rwrd_end");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
